// File: rtl/debug_scan_master_if.sv
// Pin-level bundle between the debug scan master and its responder, plus the
// start/abort/busy/done/valid handshake toward whoever requests the scan.
interface debug_scan_master_if;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       valid;
  logic [7:0] dbg_cmd_out;
  logic [7:0] dbg_rsp_in;

  modport master (input  start, abort, dbg_rsp_in,
                  output dbg_cmd_out, busy, done, valid);
  modport slave  (output start, abort, dbg_rsp_in,
                  input  dbg_cmd_out, busy, done, valid);
endinterface

// File: rtl/debug_scan_master.sv
// Debug pin scan master: reads every board cell, then current column and winner.
// Optional DEBUG_SCAN_DIFF_EN adds a `changed` flag against the previous snapshot.
module debug_scan_master #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int RESP_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  debug_scan_master_if.master      bus,
  output logic [ROWS*COLS*2-1:0]   board_out,
  output logic [2:0]               current_col_out,
  output logic [1:0]               winner_out
`ifdef DEBUG_SCAN_DIFF_EN
  ,
  output logic                     changed
`endif
);
  localparam int BW = ROWS*COLS*2;
  localparam int WW = (RESP_LAT > 2) ? $clog2(RESP_LAT) : 1;
  localparam logic [1:0] CMD_NOP = 2'd0, CMD_BOARD = 2'd1, CMD_COL = 2'd2, CMD_WIN = 2'd3;

  typedef enum logic [2:0] {IDLE, CELL, COLR, WINR, FIN} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [2:0]      row_q, row_d, col_q, col_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [BW-1:0]   board_q, board_d;
  logic [2:0]      ccol_q, ccol_d;
  logic [1:0]      win_q, win_d;
  logic            busy_q, busy_d, valid_q, valid_d;
  logic            smp, last_cell, active;

  // The response is sampled on the same edge that launches the next command.
  assign smp       = (wcnt_q == WW'(RESP_LAT-1));
  assign last_cell = (row_q == 3'(ROWS-1)) && (col_q == 3'(COLS-1));
  assign active    = (state_q == CELL) || (state_q == COLR) || (state_q == WINR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CELL;
      CELL:    if (bus.abort) state_d = IDLE; else if (smp && last_cell) state_d = COLR;
      COLR:    if (bus.abort) state_d = IDLE; else if (smp) state_d = WINR;
      WINR:    if (bus.abort) state_d = IDLE; else if (smp) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_d   = cmd_q;
    row_d   = row_q;
    col_d   = col_q;
    wcnt_d  = active ? wcnt_q + WW'(1) : '0;
    board_d = board_q;
    ccol_d  = ccol_q;
    win_d   = win_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        cmd_d = {6'd0, CMD_NOP};
        if (bus.start) begin
          row_d   = '0;
          col_d   = '0;
          cmd_d   = {6'd0, CMD_BOARD};
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      CELL, COLR, WINR: begin
        if (bus.abort) begin
          cmd_d   = {6'd0, CMD_NOP};
          row_d   = '0;
          col_d   = '0;
          wcnt_d  = '0;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end else if (smp) begin
          wcnt_d = '0;
          if (state_q == CELL) begin
            for (int r = 0; r < ROWS; r++)
              for (int c = 0; c < COLS; c++)
                if (row_q == 3'(r) && col_q == 3'(c))
                  board_d[2*(r*COLS+c) +: 2] = bus.dbg_rsp_in[1:0];
            if (last_cell) begin
              row_d = '0;
              col_d = '0;
              cmd_d = {6'd0, CMD_COL};
            end else begin
              if (col_q == 3'(COLS-1)) begin
                col_d = '0;
                row_d = row_q + 3'd1;
              end else begin
                col_d = col_q + 3'd1;
              end
              cmd_d = {row_d, col_d, CMD_BOARD};
            end
          end else if (state_q == COLR) begin
            ccol_d = bus.dbg_rsp_in[2:0];
            cmd_d  = {6'd0, CMD_WIN};
          end else begin
            win_d = bus.dbg_rsp_in[1:0];
            cmd_d = {6'd0, CMD_NOP};
          end
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
      default: cmd_d = {6'd0, CMD_NOP};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wcnt_q  <= '0;
      board_q <= '0;
      ccol_q  <= '0;
      win_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wcnt_q  <= wcnt_d;
      board_q <= board_d;
      ccol_q  <= ccol_d;
      win_q   <= win_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

`ifdef DEBUG_SCAN_DIFF_EN
  logic [BW-1:0] sh_board_q;
  logic [2:0]    sh_col_q;
  logic [1:0]    sh_win_q;
  logic          changed_q;

  // Only a completed scan (FIN) touches the shadow; aborts never reach FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_board_q <= '0;
      sh_col_q   <= '0;
      sh_win_q   <= '0;
      changed_q  <= 1'b0;
    end else if (state_q == FIN) begin
      changed_q  <= (board_q != sh_board_q) || (ccol_q != sh_col_q) || (win_q != sh_win_q);
      sh_board_q <= board_q;
      sh_col_q   <= ccol_q;
      sh_win_q   <= win_q;
    end
  end

  assign changed = changed_q;
`endif

  assign bus.dbg_cmd_out = cmd_q;
  assign bus.busy        = busy_q;
  assign bus.valid       = valid_q;
  assign bus.done        = (state_q == FIN);
  assign board_out       = board_q;
  assign current_col_out = ccol_q;
  assign winner_out      = win_q;
endmodule

// File: tb/tb_debug_scan_master.sv
// Scoreboard bench for debug_scan_master: a responder model answers commands,
// expected commands/results are queued at start and popped as the DUT emits them.
module tb_debug_scan_master;
  localparam int ROWS = 8, COLS = 8, RL = 2;
  localparam int NC = ROWS*COLS, BW = NC*2, SCAN = RL*(NC+2);

  typedef struct {
    int            done_cyc;
    logic [BW-1:0] board;
    logic [2:0]    col;
    logic [1:0]    win;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_scan_master_if bus();
  logic [BW-1:0] board;
  logic [2:0]    ccol;
  logic [1:0]    win;
`ifdef DEBUG_SCAN_DIFF_EN
  logic          changed;
`endif

  debug_scan_master #(.ROWS(ROWS), .COLS(COLS), .RESP_LAT(RL)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .board_out       (board),
    .current_col_out (ccol),
    .winner_out      (win)
`ifdef DEBUG_SCAN_DIFF_EN
    ,
    .changed         (changed)
`endif
  );

  int tests = 0, fails = 0, cyc = 0;
  logic [1:0] rsp_cell [ROWS][COLS];
  logic [2:0] rsp_col = 3'd5;
  logic [1:0] rsp_win = 2'd2;

  res_t       res_q[$];
  logic [7:0] cmd_q[$];
  logic       mon_en = 1'b0, pend = 1'b0;
  logic [7:0] last_cmd = 8'd0;
  int         last_chg = 0;
  res_t       cur;
`ifdef DEBUG_SCAN_DIFF_EN
  logic [BW-1:0] sh_board = '0;
  logic [2:0]    sh_col = '0;
  logic [1:0]    sh_win = '0;
`endif

  // Responder: answers whatever command is currently held on the pins.
  always_comb begin
    bus.dbg_rsp_in = '0;
    case (bus.dbg_cmd_out[1:0])
      2'd1:    bus.dbg_rsp_in = {6'd0, rsp_cell[bus.dbg_cmd_out[7:5]][bus.dbg_cmd_out[4:2]]};
      2'd2:    bus.dbg_rsp_in = {5'd0, rsp_col};
      2'd3:    bus.dbg_rsp_in = {6'd0, rsp_win};
      default: bus.dbg_rsp_in = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_board();
    logic [BW-1:0] b = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        b[2*(r*COLS+c) +: 2] = rsp_cell[r][c];
    return b;
  endfunction

  initial forever @(posedge clk) cyc++;

  // Monitor: pops expected commands on every pin change and results on done.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (pend) begin
        pend = 1'b0;
        chk("post_busy",  BW'(bus.busy),  BW'(0));
        chk("post_valid", BW'(bus.valid), BW'(1));
        chk("post_done",  BW'(bus.done),  BW'(0));
        chk("board",      board,          cur.board);
        chk("cur_col",    BW'(ccol),      BW'(cur.col));
        chk("winner",     BW'(win),       BW'(cur.win));
`ifdef DEBUG_SCAN_DIFF_EN
        chk("changed", BW'(changed),
            BW'((cur.board != sh_board) || (cur.col != sh_col) || (cur.win != sh_win)));
        sh_board = cur.board;
        sh_col   = cur.col;
        sh_win   = cur.win;
`endif
      end
      if (bus.dbg_cmd_out !== last_cmd) begin
        if (cmd_q.size() == 0) chk("cmd_unexpected", BW'(bus.dbg_cmd_out), BW'(last_cmd));
        else                   chk("cmd", BW'(bus.dbg_cmd_out), BW'(cmd_q.pop_front()));
        if (last_cmd != 8'd0) chk("cmd_gap", BW'(cyc - last_chg), BW'(RL));
        last_cmd = bus.dbg_cmd_out;
        last_chg = cyc;
      end
      if (bus.done) begin
        if (res_q.size() == 0) chk("spurious_done", BW'(1), BW'(0));
        else begin
          cur = res_q.pop_front();
          chk("done_cyc",   BW'(cyc),       BW'(cur.done_cyc));
          chk("done_busy",  BW'(bus.busy),  BW'(1));
          chk("done_valid", BW'(bus.valid), BW'(0));
          pend = 1'b1;
        end
      end
    end
  end

  // Drives a one-cycle start (optionally with abort) and queues the expectations.
  task automatic start_scan(input logic with_abort);
    res_t e;
    @(negedge clk); #1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (r != 0 || c != 0) cmd_q.push_back({3'(r), 3'(c), 2'd1});
        else                  cmd_q.push_back(8'h01);
    cmd_q.push_back(8'h02);
    cmd_q.push_back(8'h03);
    cmd_q.push_back(8'h00);
    e.done_cyc = cyc + 1 + SCAN;
    e.board    = exp_board();
    e.col      = rsp_col;
    e.win      = rsp_win;
    res_q.push_back(e);
    bus.start = 1'b1;
    bus.abort = with_abort;
    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((res_q.size() != 0 || pend) && n < SCAN + 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("scan_timeout", BW'(res_q.size() != 0 || pend), BW'(0));
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 bus.start = 1'b1;
    @(negedge clk); #1 bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        rsp_cell[r][c] = 2'((r + c) % 4);

    repeat (3) @(negedge clk);
    chk("rst_cmd",   BW'(bus.dbg_cmd_out), BW'(0));
    chk("rst_board", board,                '0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_cmd",   BW'(bus.dbg_cmd_out), BW'(0));
      chk("idle_busy",  BW'(bus.busy),        BW'(0));
      chk("idle_valid", BW'(bus.valid),       BW'(0));
      chk("idle_done",  BW'(bus.done),        BW'(0));
    end
    mon_en = 1'b1;

    // Plain scan of the (r+c)%4 pattern.
    start_scan(1'b0);
    wait_done();

    // Identical scan with stray start pulses near scan cycles 5 and 100.
    start_scan(1'b0);
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (93) @(negedge clk);
    pulse_start();
    wait_done();

    // Abort sampled on scan edge 40.
    start_scan(1'b0);
    repeat (39) @(negedge clk);
    #1;
    cmd_q.delete();
    cmd_q.push_back(8'h00);
    res_q.delete();
    bus.abort = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_busy",  BW'(bus.busy),        BW'(0));
    chk("abort_cmd",   BW'(bus.dbg_cmd_out), BW'(0));
    chk("abort_valid", BW'(bus.valid),       BW'(0));
    chk("abort_done",  BW'(bus.done),        BW'(0));
    bus.abort = 1'b0;
    repeat (SCAN) @(negedge clk);

    // Flip cell (7,7); start and abort together from IDLE, start must win.
    rsp_cell[ROWS-1][COLS-1] = rsp_cell[ROWS-1][COLS-1] ^ 2'd1;
    start_scan(1'b1);
    wait_done();

    // Asynchronous reset in the middle of a scan.
    start_scan(1'b0);
    repeat (50) @(negedge clk);
    #1;
    mon_en = 1'b0;
    cmd_q.delete();
    res_q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmd",   BW'(bus.dbg_cmd_out), BW'(0));
    chk("arst_busy",  BW'(bus.busy),        BW'(0));
    chk("arst_valid", BW'(bus.valid),       BW'(0));
    chk("arst_done",  BW'(bus.done),        BW'(0));
    chk("arst_board", board,                '0);
    chk("arst_col",   BW'(ccol),            BW'(0));
    chk("arst_win",   BW'(win),             BW'(0));
`ifdef DEBUG_SCAN_DIFF_EN
    chk("arst_changed", BW'(changed), BW'(0));
    sh_board = '0;
    sh_col   = '0;
    sh_win   = '0;
`endif
    @(negedge clk); #1 rst_n = 1'b1;
    pend     = 1'b0;
    last_cmd = 8'd0;
    mon_en   = 1'b1;

    // Scan after reset compares against an all-zero shadow.
    start_scan(1'b0);
    wait_done();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
